// File: rtl/alu_seq.sv
// Sequential ALU: one op per START, registered result and flags, one-cycle DONE strobe.
// MUL is an iterative shift-add multiplier that holds BUSY for DATA_WIDTH cycles.
module alu_seq #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OP_WIDTH   = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [OP_WIDTH-1:0]   OP,
   input  logic [DATA_WIDTH-1:0] IN0,
   input  logic [DATA_WIDTH-1:0] IN1,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [DATA_WIDTH-1:0] OUT,
   output logic [DATA_WIDTH-1:0] OUT_HI,
   output logic [3:0]            FLAGS
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_PA  = 4'd1,
      OP_INC = 4'd2,
      OP_PB  = 4'd3,
      OP_SUB = 4'd4,
      OP_DEC = 4'd5,
      OP_AND = 4'd6,
      OP_OR  = 4'd7,
      OP_XOR = 4'd8,
      OP_NOT = 4'd9,
      OP_SHL = 4'd10,
      OP_SHR = 4'd11,
      OP_ASR = 4'd12,
      OP_MUL = 4'd13
   } op_t;

   state_t          state, state_n;
   logic [W-1:0]    out_q, out_n;
   logic [W-1:0]    hi_q, hi_n;
   logic [3:0]      flags_q, flags_n;
   logic            done_q, done_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [2*W-1:0]  prod_q, prod_n;
   logic [W-1:0]    mcand_q, mcand_n;

   logic [3:0]      op_lo;
   logic            op_rsv;
   logic            is_mul;
   logic [W:0]      sum_ext;
   logic [W:0]      inc_ext;
   logic [W-1:0]    diff;
   logic [W-1:0]    dec;
   logic [W-1:0]    alu_res;
   logic            alu_c;
   logic            alu_v;
   logic            alu_bad;
   logic [3:0]      alu_flags;
   logic [W:0]      mul_sum;
   logic [2*W-1:0]  prod_step;

   assign op_lo   = OP[3:0];
   assign op_rsv  = (OP >> 4) != '0;
   assign is_mul  = !op_rsv && (op_lo == OP_MUL);
   assign sum_ext = {1'b0, IN0} + {1'b0, IN1};
   assign inc_ext = {1'b0, IN0} + {{W{1'b0}}, 1'b1};
   assign diff    = IN0 - IN1;
   assign dec     = IN0 - {{(W-1){1'b0}}, 1'b1};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_bad = 1'b0;
      case (op_lo)
         OP_ADD: begin
            alu_res = sum_ext[W-1:0];
            alu_c   = sum_ext[W];
            alu_v   = (IN0[W-1] == IN1[W-1]) && (sum_ext[W-1] != IN0[W-1]);
         end
         OP_PA: alu_res = IN0;
         OP_INC: begin
            alu_res = inc_ext[W-1:0];
            alu_c   = inc_ext[W];
            alu_v   = !IN0[W-1] && inc_ext[W-1];
         end
         OP_PB: alu_res = IN1;
         OP_SUB: begin
            alu_res = diff;
            alu_c   = IN0 < IN1;
            alu_v   = (IN0[W-1] != IN1[W-1]) && (diff[W-1] != IN0[W-1]);
         end
         OP_DEC: begin
            alu_res = dec;
            alu_c   = IN0 == '0;
            alu_v   = IN0[W-1] && !dec[W-1];
         end
         OP_AND: alu_res = IN0 & IN1;
         OP_OR:  alu_res = IN0 | IN1;
         OP_XOR: alu_res = IN0 ^ IN1;
         OP_NOT: alu_res = ~IN0;
         OP_SHL: begin
            alu_res = {IN0[W-2:0], 1'b0};
            alu_c   = IN0[W-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, IN0[W-1:1]};
            alu_c   = IN0[0];
         end
         OP_ASR: begin
            alu_res = {IN0[W-1], IN0[W-1:1]};
            alu_c   = IN0[0];
         end
         default: alu_bad = 1'b1;
      endcase
      if (op_rsv || alu_bad) begin
         alu_res   = '0;
         alu_flags = 4'b1000;
      end else begin
         alu_flags = {alu_res == '0, alu_res[W-1], alu_c, alu_v};
      end
   end

   // Upper half accumulates; the multiplier shifts out of the lower half as the product shifts in.
   assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_step = {mul_sum, prod_q[W-1:1]};

   always_comb begin
      state_n = state;
      out_n   = out_q;
      hi_n    = hi_q;
      flags_n = flags_q;
      done_n  = 1'b0;
      cnt_n   = cnt_q;
      prod_n  = prod_q;
      mcand_n = mcand_q;
      case (state)
         ST_IDLE: begin
            if (START) begin
               if (is_mul) begin
                  mcand_n = IN0;
                  prod_n  = {{W{1'b0}}, IN1};
                  cnt_n   = CW'(W);
                  state_n = ST_MUL;
               end else begin
                  out_n   = alu_res;
                  hi_n    = '0;
                  flags_n = alu_flags;
                  done_n  = 1'b1;
               end
            end
         end
         ST_MUL: begin
            prod_n = prod_step;
            cnt_n  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               out_n   = prod_step[W-1:0];
               hi_n    = prod_step[2*W-1:W];
               flags_n = {prod_step == '0, prod_step[2*W-1], 2'b00};
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         out_q   <= '0;
         hi_q    <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
      end else begin
         state   <= state_n;
         out_q   <= out_n;
         hi_q    <= hi_n;
         flags_q <= flags_n;
         done_q  <= done_n;
         cnt_q   <= cnt_n;
         prod_q  <= prod_n;
         mcand_q <= mcand_n;
      end
   end

   assign BUSY   = (state == ST_MUL);
   assign DONE   = done_q;
   assign OUT    = out_q;
   assign OUT_HI = hi_q;
   assign FLAGS  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DATA_WIDTH=8: hand-computed results, flags and handshake timing.
module tb_alu_seq;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic [3:0] OP = '0;
   logic [7:0] IN0 = '0;
   logic [7:0] IN1 = '0;
   logic       BUSY;
   logic       DONE;
   logic [7:0] OUT;
   logic [7:0] OUT_HI;
   logic [3:0] FLAGS;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   alu_seq #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OP(OP), .IN0(IN0), .IN1(IN1),
      .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .OUT_HI(OUT_HI), .FLAGS(FLAGS)
   );

   // Observed vector layout: {DONE, BUSY, OUT_HI, OUT, FLAGS}
   task automatic test_reset();
      logic [21:0] obs;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== 22'h0) begin
         n_bad++;
         $display("FAIL reset_state: got %h want %h", obs, 22'h0);
      end
      @(negedge CLK);
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== 22'h0) begin
         n_bad++;
         $display("FAIL reset_idle: got %h want %h", obs, 22'h0);
      end
   endtask

   task automatic test_add();
      logic [21:0] obs;
      START = 1'b1; OP = 4'd0; IN0 = 8'hFF; IN1 = 8'h01;
      @(posedge CLK); @(negedge CLK);
      START = 1'b0;
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 8'h00, 8'h00, 4'b1010}) begin
         n_bad++;
         $display("FAIL add_ff_01: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 8'h00, 4'b1010});
      end
      @(negedge CLK);
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 4'b1010}) begin
         n_bad++;
         $display("FAIL add_hold: got %h want %h", obs, {1'b0, 1'b0, 8'h00, 8'h00, 4'b1010});
      end
   endtask

   task automatic test_sub();
      logic [21:0] obs;
      START = 1'b1; OP = 4'd4; IN0 = 8'h80; IN1 = 8'h01;
      @(posedge CLK); @(negedge CLK);
      START = 1'b0;
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 8'h00, 8'h7F, 4'b0001}) begin
         n_bad++;
         $display("FAIL sub_80_01: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 8'h7F, 4'b0001});
      end
      START = 1'b1; OP = 4'd4; IN0 = 8'h00; IN1 = 8'h01;
      @(posedge CLK); @(negedge CLK);
      START = 1'b0;
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 8'h00, 8'hFF, 4'b0110}) begin
         n_bad++;
         $display("FAIL sub_00_01: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 8'hFF, 4'b0110});
      end
   endtask

   task automatic test_mul();
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at = -1;
      int first_busy = -1;
      int overlap = 0;
      logic [19:0] res;
      START = 1'b1; OP = 4'd13; IN0 = 8'hFF; IN1 = 8'hFF;
      @(posedge CLK); @(negedge CLK);
      START = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         if (BUSY) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = i;
         end
         if (DONE) begin
            done_cnt++;
            done_at = i;
         end
         if (BUSY && DONE) overlap++;
         if (i == 3) begin
            START = 1'b1; OP = 4'd0; IN0 = 8'h01; IN1 = 8'h01;
         end else begin
            START = 1'b0;
         end
         @(posedge CLK); @(negedge CLK);
      end
      n_cmp++;
      if (busy_cnt != 8 || first_busy != 1) begin
         n_bad++;
         $display("FAIL mul_busy: got cycles=%0d first=%0d want cycles=8 first=1", busy_cnt, first_busy);
      end
      n_cmp++;
      if (done_cnt != 1 || done_at != 9 || overlap != 0) begin
         n_bad++;
         $display("FAIL mul_done: got count=%0d at=%0d overlap=%0d want count=1 at=9 overlap=0",
                  done_cnt, done_at, overlap);
      end
      res = {OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (res !== {8'hFE, 8'h01, 4'b0100}) begin
         n_bad++;
         $display("FAIL mul_ff_ff: got %h want %h", res, {8'hFE, 8'h01, 4'b0100});
      end
   endtask

   task automatic test_misc_ops();
      logic [3:0]  ops  [11] = '{4'd1, 4'd3, 4'd5, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd2, 4'd0, 4'd12};
      logic [7:0]  as   [11] = '{8'h5A, 8'h00, 8'h00, 8'h80, 8'hF0, 8'h00, 8'h55, 8'h01, 8'hFF, 8'h7F, 8'h40};
      logic [7:0]  bs   [11] = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      logic [7:0]  outs [11] = '{8'h5A, 8'hA5, 8'hFF, 8'h7F, 8'h30, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h80, 8'h20};
      logic [3:0]  flgs [11] = '{4'b0000, 4'b0100, 4'b0110, 4'b0001, 4'b0000, 4'b1000, 4'b0100,
                                 4'b1010, 4'b1010, 4'b0101, 4'b0000};
      logic [21:0] obs;
      logic [21:0] exp_v;
      for (int i = 0; i < 11; i++) begin
         START = 1'b1; OP = ops[i]; IN0 = as[i]; IN1 = bs[i];
         @(posedge CLK); @(negedge CLK);
         START = 1'b0;
         obs   = {DONE, BUSY, OUT_HI, OUT, FLAGS};
         exp_v = {1'b1, 1'b0, 8'h00, outs[i], flgs[i]};
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL misc_op%0d_idx%0d: got %h want %h", ops[i], i, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [21:0] obs;
      int done_cnt = 0;
      int busy_cnt = 0;
      START = 1'b1; OP = 4'd13; IN0 = 8'h0F; IN1 = 8'h11;
      @(posedge CLK); @(negedge CLK);
      START = 1'b0;
      repeat (3) begin
         @(posedge CLK); @(negedge CLK);
      end
      RST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      RST = 1'b0;
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== 22'h0) begin
         n_bad++;
         $display("FAIL mid_mul_reset: got %h want %h", obs, 22'h0);
      end
      for (int i = 0; i < 12; i++) begin
         if (DONE) done_cnt++;
         if (BUSY) busy_cnt++;
         @(posedge CLK); @(negedge CLK);
      end
      n_cmp++;
      if (done_cnt != 0 || busy_cnt != 0) begin
         n_bad++;
         $display("FAIL mid_mul_abort: got done=%0d busy=%0d want done=0 busy=0", done_cnt, busy_cnt);
      end
      START = 1'b1; OP = 4'd2; IN0 = 8'h7F; IN1 = 8'h00;
      @(posedge CLK); @(negedge CLK);
      START = 1'b0;
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 8'h00, 8'h80, 4'b0101}) begin
         n_bad++;
         $display("FAIL inc_7f: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 8'h80, 4'b0101});
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops  [5] = '{4'd0, 4'd8, 4'd10, 4'd12, 4'd15};
      logic [7:0]  as   [5] = '{8'h01, 8'h01, 8'h81, 8'h81, 8'h12};
      logic [7:0]  bs   [5] = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h34};
      logic [7:0]  outs [5] = '{8'h03, 8'h03, 8'h02, 8'hC0, 8'h00};
      logic [3:0]  flgs [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0110, 4'b1000};
      logic [21:0] obs;
      logic [21:0] exp_v;
      for (int i = 0; i <= 5; i++) begin
         if (i > 0) begin
            obs   = {DONE, BUSY, OUT_HI, OUT, FLAGS};
            exp_v = {1'b1, 1'b0, 8'h00, outs[i-1], flgs[i-1]};
            n_cmp++;
            if (obs !== exp_v) begin
               n_bad++;
               $display("FAIL b2b_op%0d: got %h want %h", ops[i-1], obs, exp_v);
            end
         end
         if (i < 5) begin
            START = 1'b1; OP = ops[i]; IN0 = as[i]; IN1 = bs[i];
            @(posedge CLK); @(negedge CLK);
         end else begin
            START = 1'b0;
         end
      end
      @(posedge CLK); @(negedge CLK);
      obs = {DONE, BUSY, OUT_HI, OUT, FLAGS};
      n_cmp++;
      if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 4'b1000}) begin
         n_bad++;
         $display("FAIL b2b_tail: got %h want %h", obs, {1'b0, 1'b0, 8'h00, 8'h00, 4'b1000});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge CLK);
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_misc_ops();
      test_reset_mid_mul();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU with a start/done handshake, status flags and an iterative multiplier. It accepts one operation per START pulse, registers its result, and reports completion with a one-cycle DONE strobe. Opcodes 0–3 keep the existing combinational ALU encoding (SUM, IN0, INC IN0, IN1), so the datapath controller can move to this block without re-encoding those ops.

## Interface
- DATA_WIDTH, 8, operand/result width (≥2)
- OP_WIDTH, 4, opcode width (≥4; opcode bits above bit 3 must be zero, else the op is reserved)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only when BUSY=0
- OP  in  OP_WIDTH  opcode, sampled with START
- IN0  in  DATA_WIDTH  operand A, sampled with START
- IN1  in  DATA_WIDTH  operand B, sampled with START
- BUSY  out  1  multiply in progress; START ignored
- DONE  out  1  one-cycle pulse: OUT/OUT_HI/FLAGS just updated
- OUT  out  DATA_WIDTH  result (low half for MUL)
- OUT_HI  out  DATA_WIDTH  MUL high half; 0 for all other ops
- FLAGS  out  4  {Z,N,C,V}

## Operation
- Opcodes: 0 ADD A+B; 1 PASS A; 2 INC A+1; 3 PASS B; 4 SUB A−B; 5 DEC A−1; 6 AND; 7 OR; 8 XOR; 9 NOT A; 10 SHL A by 1; 11 SHR A logical; 12 ASR A; 13 MUL unsigned A×B; 14–15 reserved.
- States: IDLE, MUL. Accept = START & ~BUSY.
- IDLE, accept, op≠13: result, OUT_HI=0 and FLAGS are written on the accepting edge, and DONE=1 for the following cycle. State stays IDLE.
- IDLE, accept, op=13: operands are latched, the product accumulator is cleared and an iteration counter is loaded with DATA_WIDTH. The block goes to MUL with BUSY=1.
- MUL: one shift-add step per cycle, LSB of multiplier first. On the edge where the counter reaches 0, {OUT_HI,OUT} gets the product, FLAGS are written, BUSY→0, DONE=1 the next cycle, state→IDLE.
- Reserved op: OUT=0, OUT_HI=0, FLAGS={1,0,0,0}, DONE pulses.
- Arithmetic is modulo 2^DATA_WIDTH; MUL gives the full 2·DATA_WIDTH product.
- Z: result==0 (MUL: full product). N: MSB of OUT (MUL: MSB of OUT_HI).
- C: carry-out for ADD/INC; borrow for SUB/DEC (1 iff A<B, A==0 for DEC); bit shifted out for SHL/SHR/ASR; 0 for all other ops.
- V: two's-complement overflow for ADD/SUB/INC/DEC; 0 for all other ops.
- OUT, OUT_HI and FLAGS hold between operations. They change only on completion or reset.
- Any START while BUSY=1 is ignored: no latch, no DONE. START in the same cycle DONE is high is accepted.

## Timing
- Reset (RST high at an edge): state=IDLE; OUT=0, OUT_HI=0, FLAGS=0, BUSY=0, DONE=0; counter and accumulator cleared. RST overrides START.
- Reset mid-MUL aborts the operation; no DONE is issued for it.
- Single-cycle ops: latency 1 edge (accept edge k → DONE high in cycle k+1). Throughput is 1 op/cycle with START held high.
- MUL: accept at edge k; BUSY high cycles k+1..k+DATA_WIDTH; result written at edge k+DATA_WIDTH; DONE high in cycle k+DATA_WIDTH+1. An op can be accepted again from edge k+DATA_WIDTH+1.
- DONE is never high for more than one cycle per accepted op.

## Test plan
- Reset, then ADD IN0=0xFF IN1=0x01 (DATA_WIDTH=8) -> next cycle DONE=1, OUT=0x00, FLAGS Z=1 N=0 C=1 V=0; OUT holds after DONE drops.
- SUB 0x80−0x01 -> OUT=0x7F, V=1, C=0, N=0. SUB 0x00−0x01 -> OUT=0xFF, C=1, N=1, V=0.
- MUL 0xFF×0xFF -> BUSY high exactly 8 cycles, then DONE pulses once with OUT=0x01, OUT_HI=0xFE, Z=0, N=1.
- During MUL, pulse START with ADD 1+1 -> ignored: OUT_HI=0xFE/OUT=0x01 delivered, no extra DONE.
- RST asserted 4 cycles into MUL 0x0F×0x11 -> next cycle all outputs 0, BUSY=0, no DONE. A following INC 0x7F then gives OUT=0x80, V=1, N=1.
- START held high with ops ADD, XOR, SHL 0x81, ASR 0x81, reserved 15 on consecutive cycles -> DONE high 5 consecutive cycles. Results: 0x03 (ADD 0x01+0x02), 0x03 (XOR 0x01^0x02), then SHL 0x81 gives 0x02 with C=1, ASR 0x81 gives 0xC0 with C=1, and op 15 gives OUT=0x00 with Z=1.
